// File: rtl/mem_arbiter_2p.sv
// Two-port arbiter sharing one single-port synchronous RAM between port 0
// (CPU side) and port 1 (auxiliary master). One access per cycle, granted
// combinationally; read data returns one cycle later with a per-port strobe.
//
// Handshake: req_x is a valid that the requester holds, together with
// we_x/addr_x/wdata_x, until it sees gnt_x high. gnt_x acts as ready: the
// access is accepted in exactly the cycle where req_x && gnt_x. At most one gnt
// is high per cycle. rvalid_x is a single-cycle strobe with no back-pressure;
// the requester must take rdata_x in that cycle.
module mem_arbiter_2p #(
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 10,
  parameter int RR        = 1
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]     wdata0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [WIDTH-1:0]     rdata0,

  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_SIZE-1:0] addr1,
  input  logic [WIDTH-1:0]     wdata1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [WIDTH-1:0]     rdata1,

  output logic                 mem_cs,
  output logic                 mem_wen,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_din,
  input  logic [WIDTH-1:0]     mem_dout
);

  // Index of the port granted most recently; resets to 1 so that port 0
  // wins the first contention after reset.
  logic last_gnt;

  // Outstanding read: registered at grant, drives the rvalid strobe next cycle.
  logic pend_valid;
  logic pend_port;

  // Arbitration result for the current cycle.
  logic win_valid;
  logic win_port;
  logic win_we;

  // Pick at most one winner; nothing is granted while reset is asserted.
  always_comb begin
    win_valid = 1'b0;
    win_port  = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        win_valid = 1'b1;
        // Round-robin hands the slot to the port not served last;
        // fixed priority always favours port 0 (port 1 may starve).
        win_port  = (RR != 0) ? ~last_gnt : 1'b0;
      end else if (req0) begin
        win_valid = 1'b1;
        win_port  = 1'b0;
      end else if (req1) begin
        win_valid = 1'b1;
        win_port  = 1'b1;
      end
    end
  end

  // Grants and RAM drive follow the winner; idle cycles park the bus at zero.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    win_we   = 1'b0;
    mem_cs   = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (win_valid) begin
      mem_cs = 1'b1;
      if (win_port) begin
        gnt1     = 1'b1;
        win_we   = we1;
        mem_wen  = we1;
        mem_addr = addr1;
        mem_din  = wdata1;
      end else begin
        gnt0     = 1'b1;
        win_we   = we0;
        mem_wen  = we0;
        mem_addr = addr0;
        mem_din  = wdata0;
      end
    end
  end

  // Round-robin pointer and read-return tracking. A read granted the cycle
  // before reset still strobes during the reset cycle; reset clears the
  // pending flag only for the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= 1'b1;
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
    end else begin
      if (win_valid) begin
        last_gnt <= win_port;
      end
      pend_valid <= win_valid & ~win_we;
      pend_port  <= win_port;
    end
  end

  // Read data is the RAM's registered output, shared by both ports; the
  // strobe tells each port when it is theirs.
  always_comb begin
    rvalid0 = pend_valid & ~pend_port;
    rvalid1 = pend_valid &  pend_port;
    rdata0  = mem_dout;
    rdata1  = mem_dout;
  end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p: one round-robin instance and one
// fixed-priority instance share the same request inputs, each with its own
// behavioural RAM.
module tb_mem_arbiter_2p;

  localparam int W = 8;
  localparam int A = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared request inputs ----------------
  logic         req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [A-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] wdata0 = '0, wdata1 = '0;

  // ---------------- round-robin instance ----------------
  logic         gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, cs_a, wen_a;
  logic [W-1:0] rdata0_a, rdata1_a, din_a, dout_a;
  logic [A-1:0] maddr_a;

  mem_arbiter_2p #(.WIDTH(W), .ADDR_SIZE(A), .RR(1)) dut_rr (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .mem_cs(cs_a), .mem_wen(wen_a), .mem_addr(maddr_a), .mem_din(din_a),
    .mem_dout(dout_a)
  );

  // ---------------- fixed-priority instance ----------------
  logic         gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, cs_b, wen_b;
  logic [W-1:0] rdata0_b, rdata1_b, din_b, dout_b;
  logic [A-1:0] maddr_b;

  mem_arbiter_2p #(.WIDTH(W), .ADDR_SIZE(A), .RR(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .mem_cs(cs_b), .mem_wen(wen_b), .mem_addr(maddr_b), .mem_din(din_b),
    .mem_dout(dout_b)
  );

  // ---------------- RAM models (preloaded while reset is high) ----------------
  logic [W-1:0] mem_a [0:(1<<A)-1];
  logic [W-1:0] mem_b [0:(1<<A)-1];

  always @(posedge clk) begin
    if (reset) begin
      mem_a[10'h010] <= 8'hA5;
      for (int i = 0; i < 3; i++) begin
        mem_a[10'h100 + i] <= 8'h10 + W'(i);
        mem_a[10'h200 + i] <= 8'h20 + W'(i);
      end
    end else if (cs_a) begin
      if (wen_a) mem_a[maddr_a] <= din_a;
      else       dout_a <= mem_a[maddr_a];
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mem_b[10'h100] <= 8'h10;
      mem_b[10'h200] <= 8'h20;
    end else if (cs_b) begin
      if (wen_b) mem_b[maddr_b] <= din_b;
      else       dout_b <= mem_b[maddr_b];
    end
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];   // {port, data} of expected read returns

  // ---------------- driver ----------------
  // Applies one cycle of inputs at the falling edge, then lets combinational
  // outputs settle. Registered outputs seen here reflect the previous cycle.
  task automatic cyc(input logic rst,
                     input logic r0, input logic w0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                     input logic r1, input logic w1, input logic [A-1:0] a1, input logic [W-1:0] d1);
    @(negedge clk);
    reset = rst;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b0, 10'h010, 8'h00, 1'b1, 1'b1, 10'h020, 8'h55);
    checks++; if (gnt0_a !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b expected 0", gnt0_a); end
    checks++; if (gnt1_a !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", gnt1_a); end
    checks++; if (cs_a !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", cs_a); end
    checks++; if (wen_a !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b expected 0", wen_a); end
    checks++; if (gnt0_b !== 1'b0 || cs_b !== 1'b0) begin errors++; $display("FAIL reset_fp_gnt: got gnt0=%b cs=%b expected 0 0", gnt0_b, cs_b); end
    cyc(1'b1, 1'b1, 1'b0, 10'h010, 8'h00, 1'b1, 1'b1, 10'h020, 8'h55);
    checks++; if (rvalid0_a !== 1'b0 || rvalid1_a !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", rvalid0_a, rvalid1_a); end
  endtask

  task automatic test_single_read();
    cyc(1'b0, 1'b1, 1'b0, 10'h010, 8'h00, 1'b0, 1'b0, '0, '0);
    checks++; if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) begin errors++; $display("FAIL sr_gnt: got %b%b expected 10", gnt0_a, gnt1_a); end
    checks++; if (cs_a !== 1'b1 || wen_a !== 1'b0) begin errors++; $display("FAIL sr_cs_wen: got %b%b expected 10", cs_a, wen_a); end
    checks++; if (maddr_a !== 10'h010) begin errors++; $display("FAIL sr_addr: got %h expected 010", maddr_a); end
    idle();
    checks++; if (rvalid0_a !== 1'b1 || rvalid1_a !== 1'b0) begin errors++; $display("FAIL sr_rvalid: got %b%b expected 10", rvalid0_a, rvalid1_a); end
    checks++; if (rdata0_a !== 8'hA5) begin errors++; $display("FAIL sr_rdata: got %h expected a5", rdata0_a); end
  endtask

  task automatic test_write_read();
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 8'h3C);
    checks++; if (gnt1_a !== 1'b1 || gnt0_a !== 1'b0) begin errors++; $display("FAIL wr_gnt: got %b%b expected 01", gnt0_a, gnt1_a); end
    checks++; if (wen_a !== 1'b1 || cs_a !== 1'b1) begin errors++; $display("FAIL wr_wen: got cs=%b wen=%b expected 1 1", cs_a, wen_a); end
    checks++; if (maddr_a !== 10'h3FF || din_a !== 8'h3C) begin errors++; $display("FAIL wr_bus: got %h/%h expected 3ff/3c", maddr_a, din_a); end
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, 8'h00);
    checks++; if (gnt1_a !== 1'b1 || wen_a !== 1'b0) begin errors++; $display("FAIL rd_gnt: got gnt1=%b wen=%b expected 1 0", gnt1_a, wen_a); end
    checks++; if (rvalid0_a !== 1'b0 || rvalid1_a !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b%b expected 00", rvalid0_a, rvalid1_a); end
    idle();
    checks++; if (rvalid1_a !== 1'b1 || rvalid0_a !== 1'b0) begin errors++; $display("FAIL raw_rvalid: got %b%b expected 01", rvalid0_a, rvalid1_a); end
    checks++; if (rdata1_a !== 8'h3C) begin errors++; $display("FAIL raw_rdata: got %h expected 3c", rdata1_a); end
  endtask

  task automatic test_round_robin();
    int n0 = 0;
    int n1 = 0;
    logic exp_w;
    logic [W:0] e;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) cyc(1'b0, 1'b1, 1'b0, 10'h100 + A'(n0), '0, 1'b1, 1'b0, 10'h200 + A'(n1), '0);
      else       idle();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (rvalid0_a !== ~e[W] || rvalid1_a !== e[W]) begin errors++; $display("FAIL rr_rvalid c=%0d: got %b%b expected port %0d", c, rvalid0_a, rvalid1_a, e[W]); end
        checks++; if (dout_a !== e[W-1:0] || (e[W] ? rdata1_a : rdata0_a) !== e[W-1:0]) begin errors++; $display("FAIL rr_rdata c=%0d: got %h expected %h", c, dout_a, e[W-1:0]); end
      end else begin
        checks++; if (rvalid0_a !== 1'b0 || rvalid1_a !== 1'b0) begin errors++; $display("FAIL rr_rvalid0 c=%0d: got %b%b expected 00", c, rvalid0_a, rvalid1_a); end
      end
      if (c < 6) begin
        exp_w = c[0];
        checks++; if (gnt0_a !== ~exp_w || gnt1_a !== exp_w) begin errors++; $display("FAIL rr_gnt c=%0d: got %b%b expected port %0d", c, gnt0_a, gnt1_a, exp_w); end
        if (exp_w) begin
          exp_q.push_back({1'b1, 8'h20 + W'(n1)});
          n1++;
        end else begin
          exp_q.push_back({1'b0, 8'h10 + W'(n0)});
          n0++;
        end
      end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      idle();
      checks++; if (cs_a !== 1'b0 || wen_a !== 1'b0) begin errors++; $display("FAIL idle_cs c=%0d: got cs=%b wen=%b expected 0 0", c, cs_a, wen_a); end
      checks++; if (maddr_a !== '0 || din_a !== '0) begin errors++; $display("FAIL idle_bus c=%0d: got %h/%h expected 0/0", c, maddr_a, din_a); end
      checks++; if (rvalid0_a !== 1'b0 || rvalid1_a !== 1'b0) begin errors++; $display("FAIL idle_rvalid c=%0d: got %b%b expected 00", c, rvalid0_a, rvalid1_a); end
    end
    // Port 1 was granted last before the idle gap, so port 0 goes first.
    cyc(1'b0, 1'b1, 1'b1, 10'h050, 8'h77, 1'b1, 1'b1, 10'h051, 8'h88);
    checks++; if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0 || din_a !== 8'h77) begin errors++; $display("FAIL idle_resume0: got %b%b din=%h expected 10 77", gnt0_a, gnt1_a, din_a); end
    cyc(1'b0, 1'b1, 1'b1, 10'h052, 8'h99, 1'b1, 1'b1, 10'h051, 8'h88);
    checks++; if (gnt1_a !== 1'b1 || gnt0_a !== 1'b0 || din_a !== 8'h88) begin errors++; $display("FAIL idle_resume1: got %b%b din=%h expected 01 88", gnt0_a, gnt1_a, din_a); end
    idle();
    checks++; if (rvalid0_a !== 1'b0 || rvalid1_a !== 1'b0) begin errors++; $display("FAIL idle_wr_rvalid: got %b%b expected 00", rvalid0_a, rvalid1_a); end
  endtask

  task automatic test_fixed_priority();
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b1, 1'b0, 10'h100, '0, 1'b1, 1'b0, 10'h200, '0);
      checks++; if (gnt0_b !== 1'b1 || gnt1_b !== 1'b0) begin errors++; $display("FAIL fp_gnt c=%0d: got %b%b expected 10", c, gnt0_b, gnt1_b); end
    end
    cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h200, '0);
    checks++; if (gnt1_b !== 1'b1 || gnt0_b !== 1'b0 || maddr_b !== 10'h200) begin errors++; $display("FAIL fp_drop: got %b%b addr=%h expected 01 200", gnt0_b, gnt1_b, maddr_b); end
    idle();
    checks++; if (rvalid1_b !== 1'b1 || rdata1_b !== 8'h20) begin errors++; $display("FAIL fp_rdata: got %b/%h expected 1/20", rvalid1_b, rdata1_b); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0);
    checks++; if (gnt0_a !== 1'b1) begin errors++; $display("FAIL rm_gnt_n: got %b expected 1", gnt0_a); end
    cyc(1'b1, 1'b1, 1'b0, 10'h100, '0, 1'b1, 1'b0, 10'h200, '0);
    checks++; if (rvalid0_a !== 1'b1 || rdata0_a !== 8'hA5) begin errors++; $display("FAIL rm_rvalid_n1: got %b/%h expected 1/a5", rvalid0_a, rdata0_a); end
    checks++; if (gnt0_a !== 1'b0 || gnt1_a !== 1'b0 || cs_a !== 1'b0) begin errors++; $display("FAIL rm_gnt_n1: got %b%b cs=%b expected 00 0", gnt0_a, gnt1_a, cs_a); end
    cyc(1'b0, 1'b1, 1'b0, 10'h100, '0, 1'b1, 1'b0, 10'h200, '0);
    checks++; if (rvalid0_a !== 1'b0 || rvalid1_a !== 1'b0) begin errors++; $display("FAIL rm_rvalid_n2: got %b%b expected 00", rvalid0_a, rvalid1_a); end
    checks++; if (gnt0_a !== 1'b1 || gnt1_a !== 1'b0) begin errors++; $display("FAIL rm_first: got %b%b expected 10", gnt0_a, gnt1_a); end
    cyc(1'b0, 1'b1, 1'b0, 10'h101, '0, 1'b1, 1'b0, 10'h200, '0);
    checks++; if (gnt1_a !== 1'b1 || gnt0_a !== 1'b0) begin errors++; $display("FAIL rm_second: got %b%b expected 01", gnt0_a, gnt1_a); end
    checks++; if (rvalid0_a !== 1'b1 || rdata0_a !== 8'h10) begin errors++; $display("FAIL rm_rdata0: got %b/%h expected 1/10", rvalid0_a, rdata0_a); end
    idle();
    checks++; if (rvalid1_a !== 1'b1 || rdata1_a !== 8'h20) begin errors++; $display("FAIL rm_rdata1: got %b/%h expected 1/20", rvalid1_a, rdata1_a); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_idle();
    test_fixed_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
- Two-requester arbiter that shares one single-port synchronous RAM between a CPU-side port (port 0) and an auxiliary master (port 1), such as DMA or a display fetcher.
- The RAM has a one-cycle registered read, a chip select, and a write enable qualified by that select.
- Each cycle the arbiter picks at most one request, drives the RAM select/write/address/data lines, grants the winner in the same cycle, and routes read data back to the right port one cycle later with a valid strobe.

Parameters:
- WIDTH, 8, data width in bits (matches RAM cell size).
- ADDR_SIZE, 10, address width in bits.
- RR, 1, arbitration mode: 1 = round-robin; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 access request; held until gnt0.
- we0  in  1  port 0 write (1) / read (0); valid with req0.
- addr0  in  ADDR_SIZE  port 0 address.
- wdata0  in  WIDTH  port 0 write data.
- gnt0  out  1  port 0 request accepted this cycle (combinational).
- rvalid0  out  1  rdata0 holds port 0 read result (registered strobe).
- rdata0  out  WIDTH  read data for port 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_cs  out  1  RAM chip select.
- mem_wen  out  1  RAM write enable.
- mem_addr  out  ADDR_SIZE  RAM address.
- mem_din  out  WIDTH  RAM write data.
- mem_dout  in  WIDTH  RAM registered read data.

Behaviour:
- Clock/reset: single clock domain; reset is synchronous, active-high.
- Arbitration (combinational, every cycle):
  - Only one request: that port wins.
  - Both request, RR=1: the port not granted most recently wins.
  - Both request, RR=0: port 0 wins.
  - No request: no winner.
- Grant: gnt_x=1 only for the winner; at most one gnt high per cycle. A request is accepted in exactly the cycle its gnt is high. The requester may change req/addr/we/wdata on the next edge. The loser keeps req high and is not granted that cycle.
- RAM drive:
  - Winner present: mem_cs=1, mem_wen=we_x, mem_addr=addr_x, mem_din=wdata_x.
  - No winner: mem_cs=0, mem_wen=0, mem_addr/mem_din=0.
- Round-robin pointer (last_gnt, 1 bit, registered): updated to the winner's index on every granted cycle; unchanged on idle cycles. Reset value 1, so port 0 wins the first contention after reset. Ignored when RR=0.
- Read return:
  - Granted read in cycle N: rvalid_x=1 for exactly cycle N+1; rdata_x=mem_dout in that cycle.
  - Granted write: no rvalid.
  - Implementation: register pend_valid and pend_port at cycle N; rvalid_x = pend_valid & (pend_port==x).
- rdata0/rdata1: both continuously equal mem_dout; meaningful only while the matching rvalid is high.
- Back-to-back: a new grant may issue every cycle, including a read in N and a read in N+1 from either port. Read latency is fixed at 1 and never stalls.
- Read-after-write, same address: a write granted in N followed by a read granted in N+1 returns the new data in N+2.
- Read-during-write: impossible, since there is one access per cycle.
- Reset (asserted in a cycle):
  - gnt0=gnt1=0, mem_cs=0, mem_wen=0, regardless of req.
  - Next cycle: pend_valid=0, last_gnt=1, rvalid0=rvalid1=0.
  - A read granted in the cycle before reset asserts still returns rvalid in the reset cycle. pend_valid is registered from the prior grant; reset only clears it for the following cycle.
- Starvation: with RR=1 and both ports requesting continuously, grants strictly alternate 0,1,0,1.
- Fairness: with RR=0, port 1 may starve; this is by design.
- Width rules: no arithmetic; all buses pass through unmodified.

Test Plan:
- Reset, then single-port read: reset 2 cycles, preload mem[0x010]=0xA5; req0=1,we0=0,addr0=0x010 for one cycle -> gnt0=1, mem_cs=1, mem_wen=0 same cycle; next cycle rvalid0=1, rdata0=0xA5, rvalid1=0.
- Write then read-back: port 1 writes 0x3C to 0x3FF (gnt1=1, mem_wen=1), next cycle reads 0x3FF -> rvalid1=1 with rdata1=0x3C two cycles after the write grant; no rvalid after the write.
- Round-robin contention (RR=1): both req held 6 cycles, reads to distinct addresses -> grant sequence 0,1,0,1,0,1; each rvalid one cycle after its grant with the correct data; never both gnt high.
- Fixed priority (RR=0): both req held 4 cycles -> gnt0=1 every cycle, gnt1=0; drop req0 -> gnt1=1 in that same cycle.
- Idle: no req for 3 cycles -> mem_cs=0, mem_wen=0, no rvalid, last_gnt unchanged; next contention resumes with the port not last granted.
- Reset mid-traffic: port 0 read granted at cycle N, reset high in N+1 with both req high -> rvalid0=1 in N+1, no gnt and mem_cs=0 in N+1; N+2 rvalid=0; after release, contention grants port 0 first.
